// File: rtl/recip_unit.sv
// Memory-mapped reciprocal engine: reads a 16-bit divisor, writes floor(2^15/d) back, raises Ack.
// Optional build macro RECIP_ROUND_EN selects half-LSB upward rounding instead of truncation.
module recip_unit #(
  parameter int ADDR_W    = 8,
  parameter int OPND_ADDR = 8,
  parameter int RSLT_ADDR = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ack,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data
);

  typedef enum logic [2:0] {
    IDLE, ARMED, RD_HI, RD_LO, DIV, WR_HI, WR_LO, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] OPND_HI = ADDR_W'(OPND_ADDR);
  localparam logic [ADDR_W-1:0] OPND_LO = ADDR_W'(OPND_ADDR + 1);
  localparam logic [ADDR_W-1:0] RSLT_HI = ADDR_W'(RSLT_ADDR);
  localparam logic [ADDR_W-1:0] RSLT_LO = ADDR_W'(RSLT_ADDR + 1);

  state_t            state_q;
  logic [15:0]       divisor_q;
  logic [16:0]       quot_q;
  logic [16:0]       rem_q;
  logic [4:0]        count_q;
  logic              ack_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wr_data_q;

  logic [16:0] rem_shift;
  logic [16:0] rem_sub;
  logic        q_bit;
  logic [16:0] quot_d;
  logic [16:0] quot_src;
  logic [15:0] result;

  // Dividend is 2^16: only its MSB (consumed on the first DIV cycle) is set.
  always_comb begin
    rem_shift = (rem_q << 1) | 17'(count_q == 5'd0);
    rem_sub   = rem_shift - {1'b0, divisor_q};
    q_bit     = (rem_shift >= {1'b0, divisor_q});
    quot_d    = {quot_q[15:0], q_bit};
    quot_src  = (state_q == DIV) ? quot_d : quot_q;
    if (divisor_q == 16'd0) begin
      result = 16'hFFFF;
    end else begin
`ifdef RECIP_ROUND_EN
      result = 16'((quot_src >> 1) + {16'd0, quot_src[0]});
`else
      result = 16'(quot_src >> 1);
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      divisor_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      ack_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) state_q <= ARMED;
        end
        ARMED: begin
          if (!Start) begin
            state_q <= RD_HI;
            addr_q  <= OPND_HI;
          end
        end
        RD_HI: begin
          divisor_q[15:8] <= mem_rd_data;
          addr_q          <= OPND_LO;
          state_q         <= RD_LO;
        end
        RD_LO: begin
          divisor_q[7:0] <= mem_rd_data;
          rem_q          <= '0;
          quot_q         <= '0;
          count_q        <= '0;
          state_q        <= DIV;
        end
        DIV: begin
          rem_q   <= q_bit ? rem_sub : rem_shift;
          quot_q  <= quot_d;
          count_q <= count_q + 5'd1;
          // The last quotient bit is folded into the high result byte on this same edge.
          if (count_q == 5'd16) begin
            state_q   <= WR_HI;
            addr_q    <= RSLT_HI;
            wr_data_q <= result[15:8];
            wr_en_q   <= 1'b1;
          end
        end
        WR_HI: begin
          addr_q    <= RSLT_LO;
          wr_data_q <= result[7:0];
          state_q   <= WR_LO;
        end
        WR_LO: begin
          wr_en_q <= 1'b0;
          ack_q   <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (Start) begin
            ack_q   <= 1'b0;
            state_q <= ARMED;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Ack         = ack_q;
  assign mem_addr    = addr_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_recip_unit.sv
// Directed bench for recip_unit: byte memory model, handshake latency, results, write-pulse count.
module tb_recip_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  logic [7:0] mem [256];
  logic       host_we = 1'b0;
  logic [7:0] host_addr = 8'd0;
  logic [7:0] host_data = 8'd0;
  int         wr_count = 0;
  int         n_checks = 0;
  int         n_pass = 0;

`ifdef RECIP_ROUND_EN
  localparam logic [15:0] EXP_D3    = 16'h2AAB;
  localparam logic [15:0] EXP_DFFFF = 16'h0001;
`else
  localparam logic [15:0] EXP_D3    = 16'h2AAA;
  localparam logic [15:0] EXP_DFFFF = 16'h0000;
`endif

  recip_unit #(.ADDR_W(8), .OPND_ADDR(8), .RSLT_ADDR(10)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
  );

  always #5 Clk = ~Clk;

  assign mem_rd_data = mem[mem_addr];

  always @(posedge Clk) begin
    if (host_we) mem[host_addr] <= host_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    if (mem_wr_en) wr_count <= wr_count + 1;
  end

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr = a; host_data = d;
    @(negedge Clk);
    host_we = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    n_checks++;
    if ({Ack, mem_wr_en, mem_addr, mem_wr_data} !== 18'd0)
      $display("FAIL reset_outputs: got ack=%b we=%b addr=%h wd=%h, want all 0", Ack, mem_wr_en, mem_addr, mem_wr_data);
    else n_pass++;
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;
    n_checks++;
    if (Ack !== 1'b0 || mem_wr_en !== 1'b0)
      $display("FAIL idle_after_reset: got ack=%b we=%b, want 0 0", Ack, mem_wr_en);
    else n_pass++;
    $display("reset: outputs checked");
  endtask

  // One complete host transaction; disturb toggles Start and rewrites the operand mid-run.
  task automatic do_run(input string name, input logic [15:0] d, input logic [15:0] exp, input bit disturb);
    int cycles;
    int wc0;
    logic [15:0] got;
    @(negedge Clk);
    Start = 1'b1;
    host_write(8'd8, d[15:8]);
    host_write(8'd9, d[7:0]);
    Start = 1'b0;
    wc0 = wr_count;
    @(posedge Clk);
    cycles = 0;
    while (cycles < 40) begin
      @(posedge Clk); #1;
      cycles++;
      if (disturb) begin
        if (cycles == 4) begin host_we = 1'b1; host_addr = 8'd9; host_data = 8'h77; end
        if (cycles == 5) begin host_we = 1'b0; Start = 1'b1; end
        if (cycles == 6) Start = 1'b0;
      end
      if (Ack === 1'b1) break;
    end
    n_checks++;
    if (cycles != 21) $display("FAIL %s_latency: got %0d cycles, want 21", name, cycles);
    else n_pass++;
    got = {mem[10], mem[11]};
    n_checks++;
    if (got !== exp) $display("FAIL %s_result: got %h, want %h", name, got, exp);
    else n_pass++;
    n_checks++;
    if (wr_count - wc0 != 2) $display("FAIL %s_wr_pulses: got %0d, want 2", name, wr_count - wc0);
    else n_pass++;
    $display("run %s: d=%h result=%h latency=%0d", name, d, got, cycles);
  endtask

  task automatic test_reset_mid();
    int wc0;
    int acks;
    @(negedge Clk);
    host_write(8'd10, 8'hA5);
    host_write(8'd11, 8'h5A);
    Start = 1'b1;
    host_write(8'd8, 8'h00);
    host_write(8'd9, 8'h08);
    Start = 1'b0;
    wc0 = wr_count;
    @(posedge Clk);
    repeat (5) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    acks = 0;
    repeat (25) begin
      @(posedge Clk); #1;
      if (Ack === 1'b1) acks++;
    end
    n_checks++;
    if (acks != 0) $display("FAIL midreset_ack: got %0d ack cycles, want 0", acks);
    else n_pass++;
    n_checks++;
    if ({mem[10], mem[11]} !== 16'hA55A) $display("FAIL midreset_mem: got %h, want a55a", {mem[10], mem[11]});
    else n_pass++;
    n_checks++;
    if (wr_count != wc0) $display("FAIL midreset_writes: got %0d, want 0", wr_count - wc0);
    else n_pass++;
    $display("midreset: aborted run checked");
    do_run("after_reset", 16'h0008, 16'h1000, 1'b0);
  endtask

  task automatic test_back_to_back();
    int held;
    held = 0;
    repeat (4) begin
      @(posedge Clk); #1;
      if (Ack === 1'b1) held++;
    end
    n_checks++;
    if (held != 4) $display("FAIL ack_hold: got %0d of 4 cycles high", held);
    else n_pass++;
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk); #1;
    n_checks++;
    if (Ack !== 1'b0) $display("FAIL ack_drop: got %b, want 0", Ack);
    else n_pass++;
    $display("back_to_back: ack dropped on restart");
    do_run("b2b_d0010", 16'h0010, 16'h0800, 1'b0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0;
    test_reset();
    do_run("d0008", 16'h0008, 16'h1000, 1'b0);
    do_run("d0003", 16'h0003, EXP_D3, 1'b1);
    do_run("d0000", 16'h0000, 16'hFFFF, 1'b0);
    do_run("d0001", 16'h0001, 16'h8000, 1'b0);
    do_run("dffff", 16'hFFFF, EXP_DFFFF, 1'b0);
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/recip_unit.md
Name: recip_unit

Overview:
- Memory-mapped 16-bit reciprocal engine; the responder side of the host Start/Ack program handshake.
- The host loads the divisor bytes into data memory while holding Start high, releases Start, then waits for Ack.
- The block reads the operand, computes floor(2^15/d) by restoring division, writes the 16-bit result back to data memory, and raises Ack.
- It sits beside the CPU on the shared byte-wide data-memory port.

Parameters:
- ADDR_W, 8, data-memory byte-address width.
- OPND_ADDR, 8, address of the divisor MSB; the LSB is at OPND_ADDR+1.
- RSLT_ADDR, 10, address of the result MSB; the LSB is at RSLT_ADDR+1.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  host request; held high while the host loads the operand, and its release launches the run.
- Ack  out  1  program-complete flag; stays high until the next Start or Reset.
- mem_addr  out  ADDR_W  data-memory byte address.
- mem_rd_data  in  8  asynchronous read data for mem_addr, valid in the same cycle.
- mem_wr_en  out  1  byte write strobe, taken on the rising edge.
- mem_wr_data  out  8  write byte.

Behaviour:
- Reset is synchronous and active-high. While Reset=1 at an edge: state=IDLE, Ack=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, divisor/quotient/remainder/count registers=0.
- Reset mid-run aborts to IDLE with no further memory writes; any byte already written stays in memory.
- States: IDLE, ARMED, RD_HI, RD_LO, DIV, WR_HI, WR_LO, DONE.
- IDLE: Start=1 -> ARMED.
- ARMED: waits for Start=0. The edge that samples Start=0 (edge0) moves to RD_HI.
- RD_HI: mem_addr=OPND_ADDR; at edge1, capture d[15:8] and go to RD_LO.
- RD_LO: mem_addr=OPND_ADDR+1; at edge2, capture d[7:0], load remainder=0, count=0, and go to DIV.
- DIV: restoring division of the 17-bit dividend 2^16 by 16-bit d, one quotient bit per cycle, MSB first, 17 cycles (edges 3..19). The remainder register is 17 bits wide so a shifted remainder never overflows. Produces q17=floor(2^16/d).
- Result rule: R = q17>>1 = floor(2^15/d). If d=0, R=16'hFFFF (saturate), overriding the divider output; the divider still runs its full 17 cycles so latency is data-independent.
- WR_HI: mem_addr=RSLT_ADDR, mem_wr_data=R[15:8], mem_wr_en=1; the write is taken at edge20.
- WR_LO: mem_addr=RSLT_ADDR+1, mem_wr_data=R[7:0], mem_wr_en=1; the write is taken at edge21, then go to DONE.
- DONE: Ack=1, registered, visible right after edge21. Fixed latency: 21 cycles from edge0 to Ack.
- Ack is held in DONE while Start=0. Start=1 in DONE -> Ack=0 at that edge, state ARMED, starting a new run.
- Start toggling during RD_HI..WR_LO is ignored; the run completes.
- mem_wr_en is 0 in every state except WR_HI and WR_LO.
- Ack is asserted only in DONE.
- Address arithmetic wraps modulo 2^ADDR_W.
- Operand bytes are sampled only in RD_HI and RD_LO. Memory changes after edge2 do not affect the result.

Optional Feature:
- Macro: RECIP_ROUND_EN.
- Defined: R = (q17>>1) + q17[0], i.e. half-LSB upward rounding. The maximum is 0x8000 at d=1, so no overflow is possible. d=0 still gives 16'hFFFF.
- Undefined: truncation, R = q17>>1.
- Latency, handshake and state sequence are identical in both builds.

Test Plan:
- d=0x0008 loaded at Core[8]=0x00, Core[9]=0x08; Start 1->0 -> Ack rises 21 cycles after edge0; Core[10]=0x10, Core[11]=0x00 (0x1000) in both builds.
- d=0x0003 -> R=0x2AAA when truncating; R=0x2AAB with RECIP_ROUND_EN.
- d=0x0000 -> R=0xFFFF in both builds; latency still 21 cycles.
- d=0x0001 -> R=0x8000 in both builds. d=0xFFFF -> R=0x0000 when truncating; R=0x0001 with RECIP_ROUND_EN.
- Reset=1 for one cycle during DIV (e.g. 5 cycles after edge0) -> Ack stays 0; Core[10]/[11] keep their prior contents; next Start high/low with d=8 yields 0x1000.
- Back-to-back runs: after Ack, Start=1 -> Ack=0 at that edge. Load d=0x0010 and release Start -> R=0x0800 with correct Ack. Throughout, mem_wr_en pulses exactly twice per run.
